uart_console: RTL and testbench

Memory-mapped UART transmit console. It acts as a responder on the picorv32 native memory bus, decodes a 16-byte window, and buffers firmware byte writes in a FIFO. Bytes are serialized 8N1 on `uart_tx`. It sits beside the RAM responder on the core bus and replaces the simulation-only character port with a synthesizable console.

---
 rtl/uart_console.sv | 196 +++++++++++++++++++
 tb/tb_uart_console.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_console.sv
// uart_console: memory-mapped 8N1 UART transmit console on the picorv32
// native memory bus. A 16-byte window holds DATA (push), STATUS, and DIV.
// Firmware byte writes are buffered in a TX FIFO and serialized on uart_tx.
// Optional macro UART_CONSOLE_SIM_EN echoes every accepted byte with $write.
// o_dbg_state exposes the TX FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP).
module uart_console #(
   parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        uart_tx,
   output logic [1:0]  o_dbg_state
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [15:0] RST_DIV = 16'(CLK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   state_t r_state, w_state_nxt;

   // FIFO storage and pointers (one extra bit distinguishes full from empty)
   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0] w_count;
   logic        w_full, w_empty;

   // Transmitter datapath
   logic [15:0] r_div, r_fdiv, r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;

   // Bus response and the side effect it carries into the completion edge
   logic        r_ready;
   logic [31:0] r_rdata;
   logic        r_pend_push, r_pend_div;
   logic [7:0]  r_pbyte;
   logic [15:0] r_pdiv;

   logic        w_hit, w_is_push, w_accept, w_push, w_pop, w_bit_end;
   logic [31:0] w_rd_val;
   logic        w_unused;

   assign w_unused = &{1'b0, mem_addr[1:0], mem_wdata[31:16]};

   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // Handshake: a request is taken on the edge where mem_valid is high, the
   // address hits, and no response is currently being presented (r_ready
   // low). mem_ready is then high for exactly the following cycle. A DATA
   // push is only taken when the FIFO has room after this edge, so a full
   // FIFO stalls the core until the transmitter pops.
   assign w_hit     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !r_ready;
   assign w_is_push = (mem_addr[3:2] == 2'd0) && mem_wstrb[0];
   assign w_accept  = w_hit && !(w_is_push && w_full && !w_pop);
   assign w_push    = r_ready && r_pend_push;
   assign w_bit_end = (r_cnt == 16'd0);

   assign mem_ready   = r_ready;
   assign mem_rdata   = r_rdata;
   assign o_dbg_state = r_state;
   // Line level follows the registered FSM state; reset forces IDLE, so the
   // line returns high asynchronously.
   assign uart_tx = (r_state == S_START) ? 1'b0 :
                    (r_state == S_DATA)  ? r_shift[0] : 1'b1;

   // Read-data mux for the register being accessed
   always_comb begin
      w_rd_val = '0;
      if (mem_wstrb == 4'b0000) begin
         case (mem_addr[3:2])
            2'd1:    w_rd_val = {16'd0, 8'(w_count), 5'd0, w_empty, w_full,
                                 (r_state != S_IDLE)};
            2'd2:    w_rd_val = {16'd0, r_div};
            default: w_rd_val = '0;
         endcase
      end
   end

   // Bus response registers and DIV register update on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready     <= 1'b0;
         r_rdata     <= '0;
         r_pend_push <= 1'b0;
         r_pend_div  <= 1'b0;
         r_pbyte     <= '0;
         r_pdiv      <= '0;
         r_div       <= RST_DIV;
      end else begin
         r_ready     <= w_accept;
         r_rdata     <= w_accept ? w_rd_val : 32'd0;
         r_pend_push <= w_accept && w_is_push;
         r_pend_div  <= w_accept && (mem_addr[3:2] == 2'd2) && (&mem_wstrb[1:0]);
         if (w_accept) begin
            r_pbyte <= mem_wdata[7:0];
            r_pdiv  <= mem_wdata[15:0];
         end
         if (r_pend_div) r_div <= (r_pdiv < 16'd2) ? 16'd2 : r_pdiv;
      end
   end

   // FIFO pointers; reset discards any queued bytes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // FIFO storage write (no reset needed on the data array)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_pbyte;
   end

   // TX FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // TX FSM next state and pop decision; STOP chains straight into START
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: if (w_bit_end) w_state_nxt = S_DATA;
         S_DATA:  if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = S_STOP;
         S_STOP: begin
            if (w_bit_end) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bit timer and shift register; DIV is latched at the pop for the frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_fdiv  <= RST_DIV;
      end else if (w_pop) begin
         r_shift <= r_mem[r_rd_ptr[AW-1:0]];
         r_fdiv  <= r_div;
         r_cnt   <= r_div - 16'd1;
         r_bit   <= '0;
      end else if (r_state != S_IDLE) begin
         if (w_bit_end) begin
            r_cnt <= r_fdiv - 16'd1;
            if (r_state == S_DATA) begin
               r_shift <= {1'b0, r_shift[7:1]};
               r_bit   <= r_bit + 3'd1;
            end
         end else begin
            r_cnt <= r_cnt - 16'd1;
         end
      end
   end

`ifdef UART_CONSOLE_SIM_EN
   // Echo each accepted console byte to the simulator's stdout
   always_ff @(posedge clk) begin
      if (w_push) $write("%c", r_pbyte);
   end
`else
   // Synthesizable build: no simulator echo
`endif

endmodule

// File: tb/tb_uart_console.sv
// tb_uart_console: bus driver tasks, a cycle-sampled UART receiver feeding a
// scoreboard of expected bytes, and directed register/timing checks.
module tb_uart_console;

   localparam logic [31:0] BASE = 32'h9000_0000;
   localparam logic [31:0] A_DATA = BASE + 32'h0;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_DIV  = BASE + 32'h8;
   localparam logic [31:0] A_R3   = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_rdata;
   logic        uart_tx;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];
   int         tb_div = 868;
   bit         mon_en = 1'b0;
   int         mon_t = -1;
   logic [7:0] mon_byte;

   uart_console dut (
      .clk         (clk),
      .rst         (rst),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_rdata   (mem_rdata),
      .uart_tx     (uart_tx),
      .o_dbg_state (dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bus access, modelling the core: valid held until ready, then dropped.
   task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] rdata,
                           output int waited);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      rdata = '0;
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      while (!done && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (mem_ready) begin
            done = 1'b1;
            rdata = mem_rdata;
         end
      end
      mem_valid = 1'b0;
      mem_wstrb = '0;
      if (!done) chk("bus_timeout", n, 0);
      waited = n;
      @(posedge clk); #1;
      chk("ready_one_cycle", {31'd0, mem_ready}, 0);
      chk("rdata_zero_idle", mem_rdata, 0);
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
      logic [31:0] rd;
      int w;
      bus_xfer(addr, wdata, wstrb, rd, w);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
      int w;
      bus_xfer(addr, 32'd0, 4'b0000, rdata, w);
   endtask

   task automatic write_byte(input logic [7:0] b, output int waited);
      logic [31:0] rd;
      exp_q.push_back(b);
      bus_xfer(A_DATA, {24'd0, b}, 4'b0001, rd, waited);
   endtask

   task automatic set_div(input int d);
      bus_write(A_DIV, d, 4'b0011);
      tb_div = (d < 2) ? 2 : d;
   endtask

   task automatic wait_idle();
      logic [31:0] st;
      st = '1;
      for (int i = 0; i < 600; i++) begin
         bus_read(A_STAT, st);
         if (st == 32'h4 && exp_q.size() == 0) break;
      end
      chk("wait_idle_status", st, 32'h4);
   endtask

   // UART receiver: samples the line 1 time unit after each edge and checks
   // bits at mid-bit against the scoreboard.
   always @(posedge clk) begin
      int k;
      #1;
      if (rst || !mon_en) begin
         mon_t = -1;
      end else if (mon_t < 0) begin
         if (uart_tx == 1'b0) begin
            mon_t = 0;
            mon_byte = '0;
            start_q.push_back(cyc);
         end
      end else begin
         mon_t++;
      end
      if (mon_t >= 0 && (mon_t % tb_div) == (tb_div / 2)) begin
         k = mon_t / tb_div;
         if (k == 0) begin
            chk("rx_start_bit", {31'd0, uart_tx}, 0);
         end else if (k <= 8) begin
            mon_byte[k-1] = uart_tx;
         end else begin
            chk("rx_stop_bit", {31'd0, uart_tx}, 1);
            if (exp_q.size() == 0) chk("rx_extra_byte", {24'd0, mon_byte}, 32'hFFFF_FFFF);
            else chk("rx_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
            mon_t = -1;
         end
      end
   end

   initial begin
      logic [31:0] rd;
      int w;
      int mism;
      int zeros;
      logic [7:0] pat;
      logic exp_bit;

      // Reset block
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", {31'd0, uart_tx}, 1);
      chk("reset_ready", {31'd0, mem_ready}, 0);
      chk("reset_rdata", mem_rdata, 0);
      chk("reset_state", {30'd0, dbg_state}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // STATUS after reset, single-cycle latency
      bus_xfer(A_STAT, 32'd0, 4'b0000, rd, w);
      chk("status_reset", rd, 32'h4);
      chk("read_latency", w, 1);
      bus_read(A_DIV, rd);
      chk("div_reset", rd, 32'd868);
      bus_read(A_DATA, rd);
      chk("data_read_zero", rd, 0);
      bus_read(A_R3, rd);
      chk("reg3_read_zero", rd, 0);

      // Miss: no response at all
      mem_valid = 1'b1;
      mem_addr  = BASE + 32'h10;
      mem_wstrb = 4'b0000;
      zeros = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (mem_ready) zeros++;
      end
      mem_valid = 1'b0;
      chk("miss_no_ready", zeros, 0);

      mon_en = 1'b1;

      // DIV=4 then 0x55: exact line waveform
      set_div(4);
      bus_read(A_DIV, rd);
      chk("div_readback_4", rd, 32'd4);
      write_byte(8'h55, w);
      chk("write_latency", w, 1);
      chk("tx_high_before_start", {31'd0, uart_tx}, 1);
      pat = 8'h55;
      mism = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (c < 4)        exp_bit = 1'b0;
         else if (c < 36)  exp_bit = pat[(c / 4) - 1];
         else              exp_bit = 1'b1;
         if (uart_tx !== exp_bit) mism++;
      end
      chk("frame55_waveform", mism, 0);
      @(posedge clk); #1;
      chk("tx_idle_after_frame", {31'd0, uart_tx}, 1);
      bus_read(A_STAT, rd);
      chk("status_idle_after_frame", rd, 32'h4);
      wait_idle();

      // DIV=2, three back-to-back bytes: no idle gap between frames
      set_div(2);
      start_q.delete();
      for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)), w);
      wait_idle();
      chk("gap_frame_count", start_q.size(), 3);
      if (start_q.size() == 3) begin
         chk("gap_frame1_spacing", start_q[1] - start_q[0], 20);
         chk("gap_frame2_spacing", start_q[2] - start_q[1], 20);
      end

      // DIV=4, fill the FIFO behind an in-flight byte, then stall one more
      set_div(4);
      for (int i = 0; i < 17; i++) write_byte(8'($urandom_range(0, 255)), w);
      chk("fill_last_latency", w, 1);
      bus_read(A_STAT, rd);
      chk("status_full", rd, 32'h0000_1003);
      write_byte(8'($urandom_range(0, 255)), w);
      chk("stall_held", {31'd0, (w > 1)}, 1);
      chk("stall_bounded", {31'd0, (w <= 40)}, 1);
      wait_idle();

      // DIV clamp, partial-strobe writes
      set_div(0);
      bus_read(A_DIV, rd);
      chk("div_clamp_2", rd, 32'd2);
      bus_write(A_DIV, 32'd9, 4'b0001);
      bus_read(A_DIV, rd);
      chk("div_partial_strobe", rd, 32'd2);
      bus_write(A_DATA, 32'h41, 4'b0010);
      bus_write(A_R3, 32'hFF, 4'b1111);
      repeat (4) @(posedge clk);
      #1;
      bus_read(A_STAT, rd);
      chk("no_push_strb", rd, 32'h4);

      // Reset during DATA bit 3 with 5 bytes queued
      set_div(4);
      mon_en = 1'b0;
      for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'h00, 4'b0001);
      repeat (10) @(posedge clk);
      #3;
      chk("tx_low_in_bit3", {31'd0, uart_tx}, 0);
      rst = 1'b1;
      #1;
      chk("tx_async_reset", {31'd0, uart_tx}, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      zeros = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (uart_tx !== 1'b1) zeros++;
      end
      chk("tx_quiet_after_reset", zeros, 0);
      bus_read(A_STAT, rd);
      chk("status_after_reset", rd, 32'h4);
      bus_read(A_DIV, rd);
      chk("div_after_reset", rd, 32'd868);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
